// File: rtl/sd_block_scanner.sv
// sd_block_scanner
// Walks a contiguous range of SD blocks: one read request per block, the 512
// returned bytes land in the shared 512x8 SRAM, and the filled buffer is then
// handed to the downstream consumer through a ready/release handshake.
// The block owns the SRAM address mux; the consumer address is forwarded
// whenever the buffer is not being filled.
module sd_block_scanner #(
  parameter logic [31:0] START_BLK = 32'h2000,
  parameter int          MAX_BLKS  = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        init_finished,
  input  logic        start,
  input  logic        stop,
  output logic        sd_rd_req,
  output logic [31:0] sd_blk_addr,
  input  logic        sd_valid,
  input  logic [7:0]  sd_dout,
  output logic        sram_we,
  output logic [8:0]  sram_addr,
  output logic [7:0]  sram_din,
  input  logic [8:0]  cons_addr,
  output logic        buf_ready,
  output logic [31:0] buf_blk,
  input  logic        buf_release,
  output logic        busy,
  output logic        done,
  output logic        exhausted
);

  // Wide enough to hold MAX_BLKS itself, which is the terminal count.
  localparam int CNT_W = $clog2(MAX_BLKS + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_FILL,
    ST_READY,
    ST_DONE
  } state_t;

  state_t             state;
  logic [31:0]        blk_addr;
  logic [9:0]         fill_cnt;
  logic [CNT_W-1:0]   blk_cnt;
  logic               stop_lat;
  logic               filling;

  assign filling     = (state == ST_FILL);
  assign sd_blk_addr = blk_addr;

  // NOTE: the SRAM port is a pure mux rather than a register, because a byte
  // must be written in the very cycle sd_valid strobes it; registering it
  // would add a cycle of skew between the data and the fill counter.
  assign sram_we   = filling && sd_valid;
  assign sram_addr = filling ? fill_cnt[8:0] : cons_addr;
  assign sram_din  = filling ? sd_dout : 8'h00;

  // Run sequencer: request, fill, hand off, and decide whether to continue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      blk_addr  <= START_BLK;
      fill_cnt  <= '0;
      blk_cnt   <= '0;
      stop_lat  <= 1'b0;
      sd_rd_req <= 1'b0;
      buf_ready <= 1'b0;
      buf_blk   <= START_BLK;
      busy      <= 1'b0;
      done      <= 1'b0;
      exhausted <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below
      // reads the pre-edge value of the state it is updating.
      if (busy && stop) begin
        stop_lat <= 1'b1;
      end

      case (state)
        ST_IDLE, ST_DONE: begin
          // A stop arriving with the start is deliberately not latched.
          if (start && init_finished) begin
            blk_addr  <= START_BLK;
            blk_cnt   <= '0;
            stop_lat  <= 1'b0;
            done      <= 1'b0;
            exhausted <= 1'b0;
            busy      <= 1'b1;
            sd_rd_req <= 1'b1;
            state     <= ST_REQ;
          end
        end

        ST_REQ: begin
          sd_rd_req <= 1'b0;
          fill_cnt  <= '0;
          state     <= ST_FILL;
        end

        ST_FILL: begin
          // A stop request never truncates the block being filled.
          if (sd_valid) begin
            fill_cnt <= fill_cnt + 10'd1;
            if (fill_cnt == 10'd511) begin
              blk_cnt   <= blk_cnt + 1'b1;
              buf_ready <= 1'b1;
              buf_blk   <= blk_addr;
              state     <= ST_READY;
            end
          end
        end

        ST_READY: begin
          if (buf_release) begin
            buf_ready <= 1'b0;
            if (stop_lat || stop) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_DONE;
            end else if (blk_cnt == CNT_W'(MAX_BLKS)) begin
              done      <= 1'b1;
              exhausted <= 1'b1;
              busy      <= 1'b0;
              state     <= ST_DONE;
            end else begin
              blk_addr  <= blk_addr + 32'd1;
              sd_rd_req <= 1'b1;
              state     <= ST_REQ;
            end
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_block_scanner.sv
// tb_sd_block_scanner
// Directed bench for sd_block_scanner. Stimulus pushes the expected
// read-request / buffer-ready / run-done events into a scoreboard queue; a
// monitor on the falling edge pops and compares them as the DUT raises them.
// A behavioural SRAM captures the fill traffic for content checks, and a
// second instance with MAX_BLKS=2 covers the exhaustion path.
`timescale 1ns/1ps
module tb_sd_block_scanner;

  localparam logic [31:0] START = 32'h2000;

  typedef enum logic [1:0] {EV_REQ, EV_READY, EV_DONE} ev_kind_t;
  typedef struct packed {
    ev_kind_t    kind;
    logic [31:0] val;
  } ev_t;

  int vectors     = 0;
  int miscompares = 0;
  ev_t exp_q[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance signals
  logic        reset_n, init_finished, start, stop, sd_valid, buf_release;
  logic [7:0]  sd_dout;
  logic [8:0]  cons_addr;
  logic        sd_rd_req, sram_we, buf_ready, busy, done, exhausted;
  logic [31:0] sd_blk_addr, buf_blk;
  logic [8:0]  sram_addr;
  logic [7:0]  sram_din;

  // Second instance (MAX_BLKS=2) signals
  logic        start2, stop2, sd_valid2, buf_release2;
  logic        sd_rd_req2, sram_we2, buf_ready2, busy2, done2, exhausted2;
  logic [31:0] sd_blk_addr2, buf_blk2;
  logic [8:0]  sram_addr2;
  logic [7:0]  sram_din2;
  int          req2_cnt = 0;

  logic [7:0] mem     [512];
  logic [7:0] exp_mem [512];

  sd_block_scanner #(.START_BLK(START), .MAX_BLKS(1024)) u_dut (
    .clk(clk), .reset_n(reset_n), .init_finished(init_finished),
    .start(start), .stop(stop), .sd_rd_req(sd_rd_req),
    .sd_blk_addr(sd_blk_addr), .sd_valid(sd_valid), .sd_dout(sd_dout),
    .sram_we(sram_we), .sram_addr(sram_addr), .sram_din(sram_din),
    .cons_addr(cons_addr), .buf_ready(buf_ready), .buf_blk(buf_blk),
    .buf_release(buf_release), .busy(busy), .done(done),
    .exhausted(exhausted)
  );

  sd_block_scanner #(.START_BLK(START), .MAX_BLKS(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .init_finished(init_finished),
    .start(start2), .stop(stop2), .sd_rd_req(sd_rd_req2),
    .sd_blk_addr(sd_blk_addr2), .sd_valid(sd_valid2), .sd_dout(sd_dout),
    .sram_we(sram_we2), .sram_addr(sram_addr2), .sram_din(sram_din2),
    .cons_addr(cons_addr), .buf_ready(buf_ready2), .buf_blk(buf_blk2),
    .buf_release(buf_release2), .busy(busy2), .done(done2),
    .exhausted(exhausted2)
  );

  // Behavioural SRAM behind the main instance
  always @(posedge clk) begin
    if (sram_we) mem[sram_addr] <= sram_din;
  end

  // Count read-request cycles of the MAX_BLKS=2 instance
  always @(negedge clk) begin
    if (reset_n && sd_rd_req2) req2_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic push_exp(input ev_kind_t k, input logic [31:0] v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic got(input ev_kind_t k, input logic [31:0] v);
    ev_t e;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL sb_unexpected: got %s %h expected no event", k.name(), v);
    end else begin
      e = exp_q.pop_front();
      check({"sb_kind_", e.kind.name()}, 32'(k), 32'(e.kind));
      check({"sb_val_", e.kind.name()}, v, e.val);
    end
  endtask

  // Monitor: turn DUT output activity into events for the scoreboard
  logic prev_ready, prev_done;
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_ready = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (sd_rd_req)               got(EV_REQ, sd_blk_addr);
      if (buf_ready && !prev_ready) got(EV_READY, buf_blk);
      if (done && !prev_done)       got(EV_DONE, {31'b0, exhausted});
      prev_ready = buf_ready;
      prev_done  = done;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_valid(input int which, input logic v);
    if (which == 0) sd_valid = v;
    else            sd_valid2 = v;
  endtask

  // Wait (bounded) for the selected instance to raise its read request
  task automatic wait_req(input int which);
    for (int i = 0; i < 20; i++) begin
      if ((which == 0) ? sd_rd_req : sd_rd_req2) return;
      tick();
    end
    check("wait_req_timeout", (which == 0) ? sd_rd_req : sd_rd_req2, 1);
  endtask

  // Stream nbytes of (i+seed)%256 with a few idle gaps; optional stop and
  // release pulses at chosen byte indices (main instance only)
  task automatic feed(input int which, input int seed, input int nbytes,
                      input int stop_at, input int rel_at);
    for (int i = 0; i < nbytes; i++) begin
      if (i % 128 == 64) begin
        set_valid(which, 1'b0);
        sd_dout = 8'hEE;
        tick();
      end
      set_valid(which, 1'b1);
      sd_dout = 8'((i + seed) % 256);
      if (which == 0) begin
        stop        = (i == stop_at);
        buf_release = (i == rel_at);
        exp_mem[i]  = sd_dout;
      end
      tick();
    end
    set_valid(which, 1'b0);
    stop        = 1'b0;
    buf_release = 1'b0;
  endtask

  task automatic check_mem(input string name);
    int diffs = 0;
    for (int i = 0; i < 512; i++) begin
      if (mem[i] !== exp_mem[i]) diffs++;
    end
    check(name, diffs, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b1; init_finished = 1'b0; start = 1'b0; stop = 1'b0;
    sd_valid = 1'b0; sd_dout = 8'h00; cons_addr = 9'h000; buf_release = 1'b0;
    start2 = 1'b0; stop2 = 1'b0; sd_valid2 = 1'b0; buf_release2 = 1'b0;
    #2 reset_n = 1'b0;
    #2;
    // Reset state
    check("rst_rd_req",   sd_rd_req,   0);
    check("rst_blk_addr", sd_blk_addr, START);
    check("rst_sram_we",  sram_we,     0);
    check("rst_sram_adr", sram_addr,   0);
    check("rst_sram_din", sram_din,    0);
    check("rst_buf_rdy",  buf_ready,   0);
    check("rst_buf_blk",  buf_blk,     START);
    check("rst_busy",     busy,        0);
    check("rst_done",     done,        0);
    check("rst_exh",      exhausted,   0);
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (2) tick();

    // Start ignored while init_finished=0
    start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    check("t5_noinit_busy", busy, 0);
    check("t5_noinit_req",  sd_rd_req, 0);
    init_finished = 1'b1;

    // MAX_BLKS=2 instance runs to exhaustion
    start2 = 1'b1; tick(); start2 = 1'b0;
    wait_req(1);
    check("t4_addr0", sd_blk_addr2, START);
    tick();
    feed(1, 5, 512, -1, -1);
    check("t4_ready0", buf_ready2, 1);
    check("t4_exh0",   exhausted2, 0);
    buf_release2 = 1'b1; tick(); buf_release2 = 1'b0;
    wait_req(1);
    check("t4_addr1", sd_blk_addr2, START + 1);
    tick();
    feed(1, 9, 512, -1, -1);
    check("t4_ready1", buf_ready2, 1);
    buf_release2 = 1'b1; tick(); buf_release2 = 1'b0;
    check("t4_done",  done2,      1);
    check("t4_exh",   exhausted2, 1);
    check("t4_busy",  busy2,      0);
    check("t4_bufrdy", buf_ready2, 0);
    repeat (5) tick();
    check("t4_req_cnt", req2_cnt, 2);

    // First block of a run
    push_exp(EV_REQ, START);
    push_exp(EV_READY, START);
    start = 1'b1; tick(); start = 1'b0;
    check("t1_busy", busy, 1);
    wait_req(0);
    tick();
    check("t1_req_1cyc", sd_rd_req, 0);
    feed(0, 0, 512, -1, -1);
    check("t1_buf_ready", buf_ready, 1);
    check("t1_buf_blk",   buf_blk,   START);
    check_mem("t1_mem");

    // Consumer owns the address in READY; stray start/sd_valid ignored
    cons_addr = 9'h1A5;
    #1;
    check("t5_cons_addr", sram_addr, 9'h1A5);
    start = 1'b1; sd_valid = 1'b1; sd_dout = 8'hFF;
    #1;
    check("t5_we_ready", sram_we, 0);
    tick(); start = 1'b0;
    repeat (2) tick();
    sd_valid = 1'b0;
    check("t5_still_ready", buf_ready, 1);
    check("t5_still_busy",  busy,      1);
    check("t5_buf_blk",     buf_blk,   START);
    check_mem("t5_mem_unchanged");
    cons_addr = 9'h000;

    // Three releases without stop; one stray release mid-fill
    for (int b = 1; b <= 3; b++) begin
      push_exp(EV_REQ, START + 32'(b));
      push_exp(EV_READY, START + 32'(b));
      buf_release = 1'b1; tick(); buf_release = 1'b0;
      check("t2_ready_drop", buf_ready, 0);
      wait_req(0);
      tick();
      feed(0, b * 16, 512, -1, (b == 2) ? 300 : -1);
      check("t2_buf_blk", buf_blk, START + 32'(b));
      check_mem("t2_mem");
    end

    // Stop together with release ends the run
    push_exp(EV_DONE, 0);
    stop = 1'b1; buf_release = 1'b1; tick(); stop = 1'b0; buf_release = 1'b0;
    check("t3a_done",   done,      1);
    check("t3a_busy",   busy,      0);
    check("t3a_exh",    exhausted, 0);
    check("t3a_bufrdy", buf_ready, 0);

    // New run from DONE with simultaneous start+stop (stop not latched)
    push_exp(EV_REQ, START);
    push_exp(EV_READY, START);
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    check("t3_done_clr", done, 0);
    wait_req(0);
    tick();
    feed(0, 3, 512, -1, -1);
    push_exp(EV_REQ, START + 1);
    push_exp(EV_READY, START + 1);
    buf_release = 1'b1; tick(); buf_release = 1'b0;
    wait_req(0);
    tick();
    feed(0, 7, 512, 200, -1);
    check("t3_buf_ready", buf_ready, 1);
    check("t3_buf_blk",   buf_blk,   START + 1);
    check_mem("t3_mem");
    push_exp(EV_DONE, 0);
    buf_release = 1'b1; tick(); buf_release = 1'b0;
    check("t3_done", done,      1);
    check("t3_exh",  exhausted, 0);
    repeat (20) tick();
    check("t3_no_req", sd_rd_req, 0);

    // Reset in the middle of a fill, then a clean run
    push_exp(EV_REQ, START);
    start = 1'b1; tick(); start = 1'b0;
    wait_req(0);
    tick();
    feed(0, 8'h40, 100, -1, -1);
    sd_valid = 1'b1; sd_dout = 8'h5A;
    #2;
    check("t6_we_before", sram_we, 1);
    reset_n = 1'b0;
    #1;
    check("t6_we_rst",   sram_we,     0);
    check("t6_busy_rst", busy,        0);
    check("t6_addr_rst", sd_blk_addr, START);
    check("t6_req_rst",  sd_rd_req,   0);
    sd_valid = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    push_exp(EV_REQ, START);
    push_exp(EV_READY, START);
    start = 1'b1; tick(); start = 1'b0;
    wait_req(0);
    tick();
    feed(0, 8'h80, 512, -1, -1);
    check("t6_buf_blk", buf_blk, START);
    check_mem("t6_mem");

    repeat (5) tick();
    check("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
